rms_engine: RTL and testbench

Streaming root-mean-square engine. It accepts signed 32-bit samples with a per-sample command and keeps a running sum of squares and a sample count. On request it computes floor(sqrt(floor(sum/count))) through a fixed-latency pipeline and queues the 32-bit result in an output FIFO, which a downstream consumer drains with a pull handshake.

---
 rtl/rms_pkg.sv | 58 +++++
 rtl/rms_engine_if.sv | 14 +
 rtl/rms_out_fifo.sv | 46 ++++
 rtl/rms_engine.sv | 144 ++++++++++++++
 tb/tb_rms_engine.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rms_pkg.sv
// Shared widths, command encoding and latencies for the RMS engine, plus the
// restoring divide and integer square-root used by the emission path.
package rms_pkg;
    localparam int X_W      = 32;
    localparam int SQ_W     = 64;
    localparam int SUM_W    = 72;
    localparam int CNT_W    = 10;
    localparam int DIV_LAT  = 37;
    localparam int SQRT_LAT = 32;

    typedef enum logic [1:0] {
        CMD_ADD      = 2'b00,
        CMD_REM      = 2'b01,
        CMD_EMIT     = 2'b10,
        CMD_EMIT_CLR = 2'b11
    } cmd_t;

    // floor(s/n) truncated to 64 bits; a zero count saturates to all ones
    function automatic logic [SQ_W-1:0] div_sum(input logic [SUM_W-1:0] s,
                                                input logic [CNT_W-1:0] n);
        logic [SUM_W-1:0] q;
        logic [CNT_W:0]   rem;
        q   = '0;
        rem = '0;
        if (n == '0) begin
            q = '1;
        end else begin
            for (int i = SUM_W - 1; i >= 0; i--) begin
                rem = {rem[CNT_W-1:0], s[i]};
                if (rem >= {1'b0, n}) begin
                    rem  = rem - {1'b0, n};
                    q[i] = 1'b1;
                end
            end
        end
        return q[SQ_W-1:0];
    endfunction

    // Digit-by-digit floor(sqrt(v)), two radicand bits per iteration
    function automatic logic [X_W-1:0] isqrt(input logic [SQ_W-1:0] v);
        logic [X_W+3:0] rem;
        logic [X_W+3:0] trial;
        logic [X_W-1:0] root;
        rem  = '0;
        root = '0;
        for (int i = X_W - 1; i >= 0; i--) begin
            rem   = {rem[X_W+1:0], v[2*i+1], v[2*i]};
            trial = {2'b00, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[X_W-2:0], 1'b1};
            end else begin
                root = {root[X_W-2:0], 1'b0};
            end
        end
        return root;
    endfunction
endpackage

// File: rtl/rms_engine_if.sv
// Sample-in / result-out bundle of the RMS engine.
interface rms_engine_if;
    import rms_pkg::*;

    logic           pushin;
    logic [1:0]     cmdin;
    logic [X_W-1:0] Xin;
    logic           pullout;
    logic           stopout;
    logic [X_W-1:0] Xout;

    modport master (output pushin, cmdin, Xin, pullout, input stopout, Xout);
    modport slave  (input pushin, cmdin, Xin, pullout, output stopout, Xout);
endinterface

// File: rtl/rms_out_fifo.sv
// First-word fall-through result FIFO; writes are dropped while full.
module rms_out_fifo
    import rms_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [X_W-1:0] wr_data,
    input  logic           rd_en,
    output logic [X_W-1:0] rd_data,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    logic [X_W-1:0] mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           do_write;
    logic           do_read;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/rms_engine.sv
// Streaming RMS: square, accumulate, then floor(sqrt(S/N)) through a
// fixed-latency divide/sqrt path into the output FIFO.
module rms_engine
    import rms_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    rms_engine_if.slave bus
);
    // The FIFO write edge itself closes the last sqrt cycle
    localparam int SQRT_REGS = SQRT_LAT - 1;

    logic           in_valid_reg;
    cmd_t           in_cmd_reg;
    logic [X_W-1:0] in_x_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_valid_reg <= 1'b0;
            in_cmd_reg   <= CMD_ADD;
            in_x_reg     <= '0;
        end else begin
            in_valid_reg <= bus.pushin;
            in_cmd_reg   <= cmd_t'(bus.cmdin);
            in_x_reg     <= bus.Xin;
        end
    end

    logic signed [SQ_W-1:0] x_ext;
    logic [SQ_W-1:0]        prod;
    logic [2:0]             sq_valid_reg;
    cmd_t                   sq_cmd_reg [3];
    logic [SQ_W-1:0]        sq_val_reg [3];

    assign x_ext = {{(SQ_W-X_W){in_x_reg[X_W-1]}}, in_x_reg};
    assign prod  = x_ext * x_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) sq_valid_reg <= '0;
        else        sq_valid_reg <= {sq_valid_reg[1:0], in_valid_reg};
    end

    // Square lands at E1 and is retimed so the accumulator consumes it at E4
    always_ff @(posedge clk) begin
        sq_cmd_reg[0] <= in_cmd_reg;
        sq_val_reg[0] <= prod;
        for (int k = 1; k < 3; k++) begin
            sq_cmd_reg[k] <= sq_cmd_reg[k-1];
            sq_val_reg[k] <= sq_val_reg[k-1];
        end
    end

    logic [SUM_W-1:0] sum_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [SUM_W-1:0] sq_ext;
    logic [SUM_W-1:0] sum_add;
    logic [CNT_W-1:0] cnt_inc;
    logic             snap_valid_reg;
    logic [SUM_W-1:0] snap_sum_reg;
    logic [CNT_W-1:0] snap_cnt_reg;

    assign sq_ext  = {{(SUM_W-SQ_W){1'b0}}, sq_val_reg[2]};
    assign sum_add = sum_reg + sq_ext;
    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg        <= '0;
            cnt_reg        <= '0;
            snap_valid_reg <= 1'b0;
            snap_sum_reg   <= '0;
            snap_cnt_reg   <= '0;
        end else begin
            snap_valid_reg <= 1'b0;
            snap_sum_reg   <= sum_add;
            snap_cnt_reg   <= cnt_inc;
            if (sq_valid_reg[2]) begin
                case (sq_cmd_reg[2])
                    CMD_ADD: begin
                        sum_reg <= sum_add;
                        cnt_reg <= cnt_inc;
                    end
                    CMD_REM: begin
                        sum_reg <= sum_reg - sq_ext;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                    CMD_EMIT: begin
                        sum_reg        <= sum_add;
                        cnt_reg        <= cnt_inc;
                        snap_valid_reg <= 1'b1;
                    end
                    default: begin
                        sum_reg        <= '0;
                        cnt_reg        <= '0;
                        snap_valid_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic [SQ_W-1:0]                 quot;
    logic [DIV_LAT-1:0]              div_valid_reg;
    logic [DIV_LAT-1:0][SQ_W-1:0]    div_q_reg;
    logic [X_W-1:0]                  root;
    logic [SQRT_REGS-1:0]            sqrt_valid_reg;
    logic [SQRT_REGS-1:0][X_W-1:0]   sqrt_r_reg;

    assign quot = div_sum(snap_sum_reg, snap_cnt_reg);
    assign root = isqrt(div_q_reg[DIV_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_valid_reg  <= '0;
            sqrt_valid_reg <= '0;
        end else begin
            div_valid_reg  <= {div_valid_reg[DIV_LAT-2:0], snap_valid_reg};
            sqrt_valid_reg <= {sqrt_valid_reg[SQRT_REGS-2:0], div_valid_reg[DIV_LAT-1]};
        end
    end

    always_ff @(posedge clk) begin
        div_q_reg  <= {div_q_reg[DIV_LAT-2:0], quot};
        sqrt_r_reg <= {sqrt_r_reg[SQRT_REGS-2:0], root};
    end

    logic fifo_full;
    logic fifo_empty;

    rms_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (sqrt_valid_reg[SQRT_REGS-1]),
        .wr_data (sqrt_r_reg[SQRT_REGS-1]),
        .rd_en   (bus.pullout),
        .rd_data (bus.Xout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.stopout = fifo_empty;
endmodule

// File: tb/tb_rms_engine.sv
// Directed bench for rms_engine: hand-computed RMS results, exact latency,
// clear/remove/wrap corners and FIFO overflow/drain.
module tb_rms_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    rms_engine_if bus();

    rms_engine #(.FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic push(input logic [31:0] x, input logic [1:0] c);
        bus.pushin = 1'b1;
        bus.cmdin  = c;
        bus.Xin    = x;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pushin = 1'b0;
        bus.cmdin  = 2'b00;
        bus.Xin    = '0;
    endtask

    task automatic do_reset();
        idle();
        bus.pullout = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a result, check it, then pop it
    task automatic expect_result(input string tag, input logic [31:0] exp);
        int n = 0;
        while (bus.stopout === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_ready"}, 64'(bus.stopout), 64'd0);
        check_eq(tag, 64'(bus.Xout), 64'(exp));
        bus.pullout = 1'b1;
        @(posedge clk);
        #1;
        bus.pullout = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.pullout = 1'b0;

        // Reset state and quiescence
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_stopout", 64'(bus.stopout), 64'd1);
        check_eq("reset_xout", 64'(bus.Xout), 64'd0);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_eq("idle_100_stopout", 64'(bus.stopout), 64'd1);

        // Reset while a result is in flight discards it
        push(32'd9, 2'b11);
        idle();
        repeat (40) @(posedge clk);
        #1;
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        check_eq("midreset_discard", 64'(bus.stopout), 64'd1);

        // Basic emit with exact latency: 75/3 = 25 -> 5
        do_reset();
        push(32'd5, 2'b00);
        push(32'd5, 2'b00);
        push(-32'sd5, 2'b10);
        idle();
        repeat (72) @(posedge clk);
        #1;
        check_eq("basic_stop_e72", 64'(bus.stopout), 64'd1);
        @(posedge clk);
        #1;
        check_eq("basic_stop_e73", 64'(bus.stopout), 64'd0);
        expect_result("basic_x", 32'd5);
        check_eq("basic_drained", 64'(bus.stopout), 64'd1);

        // Remove: 200/2 = 100 -> 10
        do_reset();
        push(32'd10, 2'b00);
        push(32'd7, 2'b00);
        push(32'd7, 2'b01);
        push(32'd10, 2'b10);
        idle();
        expect_result("remove_x", 32'd10);

        // Clear: 25/2 = 12 -> 3, then fresh 4/1 -> 2
        do_reset();
        push(32'd3, 2'b00);
        push(32'd4, 2'b11);
        push(32'd2, 2'b10);
        idle();
        expect_result("clear_first", 32'd3);
        expect_result("clear_second", 32'd2);

        // Most negative sample: 2^62 / 1 -> 2^31
        do_reset();
        push(32'h8000_0000, 2'b11);
        idle();
        expect_result("min_sample", 32'h8000_0000);

        // Count wrap: 1024 ones leave N = 0, then one more gives 1024/1 -> 32
        for (int i = 0; i < 1024; i++) push(32'd1, 2'b00);
        push(32'd0, 2'b10);
        idle();
        expect_result("count_wrap", 32'd32);

        // Divide by zero via wrap: remove then add+emit -> N = 0
        do_reset();
        push(32'd1, 2'b01);
        push(32'd0, 2'b10);
        idle();
        expect_result("div_zero", 32'hFFFF_FFFF);

        // FIFO overflow: 17 emissions, 16 kept in order, 17th dropped
        do_reset();
        for (int i = 0; i < 17; i++) push(32'(100 + i), 2'b11);
        idle();
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) expect_result($sformatf("fifo_%0d", i), 32'(100 + i));
        check_eq("fifo_empty_after_16", 64'(bus.stopout), 64'd1);

        // Pop requests while empty are ignored
        bus.pullout = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.pullout = 1'b0;
        check_eq("empty_pull_stopout", 64'(bus.stopout), 64'd1);
        check_eq("empty_pull_xout", 64'(bus.Xout), 64'd0);
        push(32'd7, 2'b11);
        idle();
        expect_result("after_empty_pull", 32'd7);
        check_eq("final_empty", 64'(bus.stopout), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
